// File: rtl/ev_mon_pkg.sv
// ev_mon_pkg: shared record format for the event monitor.
// Exports REC_W, field offsets, the record kind enum and the packed record struct.
package ev_mon_pkg;
   localparam int REC_W    = 72;
   localparam int ID_W     = 6;
   localparam int MAX_SRC  = 1 << ID_W;
   localparam int TS_LSB   = 0;
   localparam int ID_LSB   = 64;
   localparam int KIND_LSB = 70;
   typedef enum logic [1:0] {EVT = 2'b01, DROP = 2'b10} rec_kind_e;
   typedef struct packed {
      rec_kind_e               kind;
      logic [ID_W-1:0]         id;
      logic [ID_LSB-TS_LSB-1:0] ts;
   } rec_t;
endpackage

// File: rtl/event_capture_if.sv
// event_capture_if: push port toward the downstream synchronous FIFO.
// fifo_full (FIFO -> producer), fifo_push / fifo_push_data (producer -> FIFO).
interface event_capture_if
   import ev_mon_pkg::*;
   ;
   logic             fifo_full;
   logic             fifo_push;
   logic [REC_W-1:0] fifo_push_data;
   modport master (input fifo_full, output fifo_push, fifo_push_data);
   modport slave (output fifo_full, input fifo_push, fifo_push_data);
endinterface

// File: rtl/event_capture_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts at ptr and wraps.
// Ports: req (request vector), ptr (start index), gnt (one-hot), idx (grant index), any (some request).
module rr_arbiter #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         any
);
   assign any = |req;
   // Walk from the farthest candidate back to ptr so the nearest hit wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            gnt = '0;
            gnt[(int'(ptr) + k) % N] = 1'b1;
            idx = W'((int'(ptr) + k) % N);
         end
      end
   end
endmodule

// File: rtl/event_capture.sv
// event_capture: rising-edge capture with per-source timestamp slots, round-robin drain into a FIFO.
// Ports: clk, rst_n (async, active-low), enable, ev_in, clear_drops, fifo (event_capture_if.master),
//        pending (slot occupied), drop_cnt (saturating lost-edge count).
// Optional feature: define EVCAP_DROP_MARKER_EN to emit drop-marker records ahead of event records.
module event_capture
   import ev_mon_pkg::*;
#(
   parameter int N_SRC = 8,
   parameter int TS_W  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [N_SRC-1:0]  ev_in,
   input  logic              clear_drops,
   event_capture_if.master   fifo,
   output logic [N_SRC-1:0]  pending,
   output logic [31:0]       drop_cnt
);
   localparam int PTR_W = $clog2(N_SRC);

   if (N_SRC < 2 || N_SRC > MAX_SRC) begin : g_bad_n_src
      $error("event_capture: N_SRC must be 2..64 to fit the 6-bit id field");
   end
   if (TS_W != 64) begin : g_bad_ts_w
      $error("event_capture: TS_W is fixed at 64 by the record format");
   end

   logic [TS_W-1:0]  ts;
   logic [TS_W-1:0]  ts_slot [N_SRC];
   logic [N_SRC-1:0] ev_q, edges, gnt, take, drops;
   logic [PTR_W-1:0] rr_ptr, gidx;
   logic             any, push, marker;
   logic [6:0]       n_drop;
   logic [32:0]      cnt_sum;
   rec_t             evt_rec, marker_rec;

   rr_arbiter #(.N(N_SRC)) u_arb (
      .req (pending),
      .ptr (rr_ptr),
      .gnt (gnt),
      .idx (gidx),
      .any (any)
   );

   assign edges = ev_in & ~ev_q & {N_SRC{enable}};
   assign push  = enable & any & ~fifo.fifo_full;
   // A marker occupies the push slot, so no source is taken in that cycle.
   assign take  = gnt & {N_SRC{push & ~marker}};
   // A taken slot re-arms on a simultaneous edge, so only untaken occupied slots lose edges.
   assign drops = edges & pending & ~take;

   always_comb begin
      n_drop = '0;
      for (int i = 0; i < N_SRC; i++) n_drop = n_drop + 7'(drops[i]);
   end

   assign cnt_sum = (clear_drops ? 33'd0 : {1'b0, drop_cnt}) + 33'(n_drop);
   assign evt_rec = '{kind: EVT, id: ID_W'(gidx), ts: ts_slot[gidx]};

`ifdef EVCAP_DROP_MARKER_EN
   logic [31:0] drop_delta;
   logic [32:0] delta_sum;
   assign marker     = |drop_delta;
   assign marker_rec = '{kind: DROP, id: '0, ts: {drop_delta, ts[31:0]}};
   assign delta_sum  = {1'b0, drop_delta} + 33'(n_drop);
   // After a marker goes out, only drops from that same cycle remain unreported.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_delta <= '0;
      else if (push && marker) drop_delta <= 32'(n_drop);
      else drop_delta <= delta_sum[32] ? '1 : delta_sum[31:0];
   end
`else
   assign marker     = 1'b0;
   assign marker_rec = '0;
`endif

   assign fifo.fifo_push      = push;
   assign fifo.fifo_push_data = push ? (marker ? marker_rec : evt_rec) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts       <= '0;
         ev_q     <= '0;
         pending  <= '0;
         rr_ptr   <= '0;
         drop_cnt <= '0;
         for (int i = 0; i < N_SRC; i++) ts_slot[i] <= '0;
      end else begin
         ts       <= ts + 1'b1;
         ev_q     <= ev_in;
         drop_cnt <= cnt_sum[32] ? '1 : cnt_sum[31:0];
         if (|take) rr_ptr <= (gidx == PTR_W'(N_SRC - 1)) ? '0 : gidx + 1'b1;
         for (int i = 0; i < N_SRC; i++) begin
            if (edges[i] && (!pending[i] || take[i])) begin
               pending[i] <= 1'b1;
               ts_slot[i] <= ts;
            end else if (take[i]) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_event_capture.sv
// tb_event_capture: directed and random stimulus against a cycle-level behavioural model of event_capture.
module tb_event_capture;
   import ev_mon_pkg::*;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         enable = 1'b0;
   logic         clear_drops = 1'b0;
   logic [N-1:0] ev_in = '0;
   logic [N-1:0] pending;
   logic [31:0]  drop_cnt;

   event_capture_if bus ();

   event_capture #(.N_SRC(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .ev_in       (ev_in),
      .clear_drops (clear_drops),
      .fifo        (bus),
      .pending     (pending),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   bit [N-1:0]      m_pend;
   longint unsigned m_slot [N];
   int              m_ptr;
   longint unsigned m_ts, m_dcnt, m_delta;
   bit [N-1:0]      m_prev;

   logic             last_push;
   logic [71:0]      last_data;
   logic [N-1:0]     last_pend;
   logic [31:0]      last_dcnt;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend  = '0;
      m_ptr   = 0;
      m_ts    = 0;
      m_dcnt  = 0;
      m_delta = 0;
      m_prev  = '0;
      for (int i = 0; i < N; i++) m_slot[i] = 0;
   endtask

   // One clock: predict and check outputs mid-cycle, then advance the model at the edge.
   task automatic step();
      bit [N-1:0]  edges;
      bit          push, mk;
      int          g, nd;
      logic [71:0] exp_data;
      @(negedge clk);
      g = -1;
      nd = 0;
      mk = 1'b0;
      for (int i = 0; i < N; i++) edges[i] = enable && ev_in[i] && !m_prev[i];
      push = enable && (m_pend != '0) && !bus.fifo_full;
`ifdef EVCAP_DROP_MARKER_EN
      mk = (m_delta != 0);
`endif
      exp_data = '0;
      if (push && mk) begin
         exp_data = {2'b10, 6'd0, m_delta[31:0], m_ts[31:0]};
      end else if (push) begin
         for (int k = 0; k < N; k++)
            if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         exp_data = {2'b01, 6'(g), m_slot[g]};
      end
      for (int i = 0; i < N; i++) if (edges[i] && m_pend[i] && i != g) nd++;
      chk("push", 72'(bus.fifo_push), 72'(push));
      chk("data", bus.fifo_push_data, exp_data);
      chk("pending", 72'(pending), 72'(m_pend));
      chk("drop_cnt", 72'(drop_cnt), 72'(m_dcnt));
      last_push = bus.fifo_push;
      last_data = bus.fifo_push_data;
      last_pend = pending;
      last_dcnt = drop_cnt;
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (edges[i] && (!m_pend[i] || i == g)) begin
            m_pend[i] = 1'b1;
            m_slot[i] = m_ts;
         end else if (i == g) begin
            m_pend[i] = 1'b0;
         end
      end
      m_dcnt = (clear_drops ? 0 : m_dcnt) + nd;
      if (m_dcnt > 64'hFFFF_FFFF) m_dcnt = 64'hFFFF_FFFF;
      m_delta = (push && mk) ? nd : m_delta + nd;
      if (m_delta > 64'hFFFF_FFFF) m_delta = 64'hFFFF_FFFF;
      if (g >= 0) m_ptr = (g + 1) % N;
      m_ts++;
      m_prev = ev_in;
      #1;
   endtask

   task automatic cyc(input logic [N-1:0] e, input logic f = 1'b0, input logic c = 1'b0);
      ev_in = e;
      bus.fifo_full = f;
      clear_drops = c;
      step();
   endtask

   initial begin
      bus.fifo_full = 1'b0;
      enable = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_push", 72'(bus.fifo_push), 72'(0));
      chk("rst_data", bus.fifo_push_data, 72'(0));
      chk("rst_pending", 72'(pending), 72'(0));
      chk("rst_drop_cnt", 72'(drop_cnt), 72'(0));
      rst_n = 1'b1;

      // Single edge on source 3 at ts=10.
      repeat (10) cyc('0);
      cyc(8'h08);
      cyc(8'h08);
      chk("t1_push", 72'(last_push), 72'(1));
      chk("t1_rec", last_data, {2'b01, 6'd3, 64'd10});
      cyc('0);
      chk("t1_pend3", 72'(last_pend[3]), 72'(0));

      // Move rr_ptr to 3 by granting source 2, then simultaneous edges on 0, 2, 5 at ts=15.
      cyc(8'h04);
      cyc('0);
      cyc(8'h25);
      cyc(8'h25);
      chk("t2_first", last_data, {2'b01, 6'd5, 64'd15});
      cyc(8'h25);
      chk("t2_second", last_data, {2'b01, 6'd0, 64'd15});
      cyc(8'h25);
      chk("t2_third", last_data, {2'b01, 6'd2, 64'd15});
      cyc('0);
      chk("t2_drained", 72'(last_pend), 72'(0));

      // FIFO full for 20 cycles while source 1 pulses 4 times starting at ts=20.
      for (int k = 0; k < 20; k++) begin
         cyc((k % 2 == 0 && k < 8) ? 8'h02 : 8'h00, 1'b1);
         chk("t3_stall", 72'(last_push), 72'(0));
      end
      cyc('0);
      chk("t3_drops", 72'(last_dcnt), 72'(3));
`ifdef EVCAP_DROP_MARKER_EN
      chk("t3_marker", last_data, {2'b10, 6'd0, 32'd3, 32'd40});
      cyc('0);
      chk("t3_rec", last_data, {2'b01, 6'd1, 64'd20});
`else
      chk("t3_rec", last_data, {2'b01, 6'd1, 64'd20});
      cyc('0);
      chk("t3_idle", 72'(last_push), 72'(0));
`endif

      // Source 2 re-edges in the cycle it is granted.
      cyc(8'h04, 1'b1);
      cyc(8'h00, 1'b1);
      cyc(8'h04);
      chk("t4_first", last_data, {2'b01, 6'd2, 64'd42});
      cyc(8'h04);
      chk("t4_second", last_data, {2'b01, 6'd2, 64'd44});
      cyc('0);
      chk("t4_no_drop", 72'(last_dcnt), 72'(3));

      // Clear, then 5 drops on source 6 under back-pressure.
      cyc('0, 1'b0, 1'b1);
      for (int k = 0; k < 12; k++) cyc((k % 2 == 0) ? 8'h40 : 8'h00, 1'b1);
      cyc('0);
      chk("t5_drops", 72'(last_dcnt), 72'(5));
`ifdef EVCAP_DROP_MARKER_EN
      chk("t5_marker_kind", 72'(last_data[KIND_LSB +: 2]), 72'(DROP));
      chk("t5_marker_cnt", 72'(last_data[63:32]), 72'(5));
      cyc('0);
      chk("t5_rec", last_data, {2'b01, 6'd6, 64'd48});
`else
      chk("t5_kind", 72'(last_data[KIND_LSB +: 2]), 72'(EVT));
      chk("t5_rec", last_data, {2'b01, 6'd6, 64'd48});
      cyc('0);
`endif
      // Clear coinciding with a drop leaves a count of 1.
      cyc(8'h40, 1'b1);
      cyc(8'h00, 1'b1);
      cyc(8'h40, 1'b1, 1'b1);
      cyc('0);
      chk("t5_clear_drop", 72'(last_dcnt), 72'(1));
      cyc('0);
      cyc('0);

      // Asynchronous reset with 4 slots pending.
      cyc(8'h0F, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_pending", 72'(pending), 72'(0));
      chk("t6_drop_cnt", 72'(drop_cnt), 72'(0));
      chk("t6_push", 72'(bus.fifo_push), 72'(0));
      @(posedge clk);
      #1;
      model_reset();
      ev_in = '0;
      bus.fifo_full = 1'b0;
      rst_n = 1'b1;
      cyc(8'h01);
      cyc(8'h01);
      chk("t6_ts_restart", last_data, {2'b01, 6'd0, 64'd0});
      chk("t6_id_field", 72'(last_data[ID_LSB +: ID_W]), 72'(0));
      cyc('0);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         enable = ($urandom_range(0, 9) != 0);
         cyc(ev_in ^ N'($urandom & $urandom & $urandom),
             $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/event_capture.md
# event_capture

Front-end stage of the event monitor: detects rising edges on `N_SRC` event lines, timestamps each edge and holds it in a per-source pending slot, then round-robin arbitrates pending slots into 72-bit records pushed into the downstream synchronous FIFO. It absorbs FIFO back-pressure via the pending slots and accounts for any edges that are lost because their slot is still occupied.

## Interface
- `N_SRC`, default 8: number of event sources, 2..64.
- `TS_W`, default 64: timestamp counter width, fixed at 64 for the record format.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: capture and push enable.
- `ev_in`, in, `N_SRC`: level event inputs, already synchronous to `clk`.
- `clear_drops`, in, 1: synchronous clear of `drop_cnt`.
- `fifo_full`, in, 1: full flag from the FIFO.
- `fifo_push`, out, 1: push strobe to the FIFO.
- `fifo_push_data`, out, 72: record to the FIFO.
- `pending`, out, `N_SRC`: per-source slot-occupied status.
- `drop_cnt`, out, 32: saturating count of lost edges.

## Operation
- `ts`: free-running 64-bit counter. Reset 0, +1 every cycle, wraps at 2^64.
- `ev_q`: registered copy of `ev_in`. Reset 0. It always tracks `ev_in`, including while `enable`=0.
- Edge on source i: `ev_in[i] & ~ev_q[i] & enable`.
- Edge on a free slot sets `pending[i]` and stores `ts_slot[i] <= ts`.
- Edge on an occupied slot that is not granted this cycle is a drop:
  - `drop_cnt` increments, saturating at 0xFFFF_FFFF.
  - The stored timestamp is kept.
- Edge on the slot granted this cycle re-arms it with the new timestamp. This is not a drop.
- Push condition: `fifo_push = enable & |pending & ~fifo_full`. The output is combinational.
- Grant: round-robin. Search starts at `rr_ptr` and wraps. On a grant, `rr_ptr <= grant+1` mod `N_SRC`. Reset `rr_ptr`=0.
- Event record: [71:70]=2'b01, [69:64]=source id, [63:0]=`ts_slot`.
- When `fifo_push`=0, `fifo_push_data` is 0.
- `clear_drops` sets `drop_cnt` to 0. If a drop occurs in the same cycle, the result is 1.
- `enable`=0:
  - No captures and no pushes.
  - `pending` and `ts_slot` are retained.
  - `ts` keeps running.

## Timing
- `ev_in[i]` goes high in cycle c (sampled at posedge P), with the slot free, `enable`=1 and the FIFO not full:
  - `pending[i]`=1 after P.
  - `fifo_push`=1 in cycle c+1.
  - The FIFO writes at posedge P+1.
  - The record timestamp equals `ts` in cycle c.
- Throughput: one record per cycle while the FIFO is not full.
- `fifo_full` stalls pushes in the same cycle, so `fifo_push` is never asserted while `fifo_full`=1.
- All `N_SRC` slots pending with no new edges: the slots drain in `N_SRC` consecutive cycles, in round-robin order starting at `rr_ptr`.
- Reset mid-operation: all state is cleared immediately. That covers `pending`, `ts_slot`, `ts`, `ev_q`, `rr_ptr` and `drop_cnt`, plus the marker state when compiled in. Outputs go to 0.

## Configuration
- Macro: `EVCAP_DROP_MARKER_EN`.
- Defined:
  - A 32-bit `drop_delta` counts drops since the last marker, saturating.
  - While `drop_delta`≠0, the next push opportunity emits a marker instead of an event record.
  - Marker format: [71:70]=2'b10, [69:64]=0, [63:32]=`drop_delta`, [31:0]=`ts`[31:0].
  - After the marker is pushed, `drop_delta` is reloaded with the number of drops in that same cycle.
  - A marker does not advance `rr_ptr`.
  - `clear_drops` does not affect `drop_delta`.
- Undefined: no markers and no `drop_delta` logic. Only `drop_cnt` reports drops.

## Structure
- Package `ev_mon_pkg`:
  - `REC_W`=72.
  - `rec_kind_e`: EVT=2'b01, DROP=2'b10.
  - Field offset constants.
  - Typed record struct.
- Sub-module `rr_arbiter`, parameterised by `N`:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, any-grant.
- Elaboration check: `N_SRC` must be ≤ 64 to fit the 6-bit id field.

## Test plan
- Single edge on source 3 at `ts`=10, FIFO empty -> one push next cycle with data {2'b01, 6'd3, 64'd10}, and `pending[3]` clears.
- Simultaneous edges on sources 0, 2, 5 with `rr_ptr`=3 -> pushes in order 5, 0, 2 on three consecutive cycles, each with the same timestamp.
- Hold `fifo_full`=1 for 20 cycles while source 1 pulses 4 times -> `fifo_push` stays 0, `drop_cnt`=3, and after release one record carries the first-edge timestamp.
- Source 2 re-edges in the cycle it is granted -> no drop, and a second record follows with the new timestamp.
- With `EVCAP_DROP_MARKER_EN`, 5 drops then release of the full condition -> first push is a marker with [63:32]=5, then the event records follow. Without the macro, no marker is pushed.
- Assert `rst_n` low with 4 slots pending -> `pending`=0, `drop_cnt`=0 and `fifo_push`=0 immediately. After release, `ts` restarts at 0.
